ovf_trap_unit: RTL and testbench

- Registered, parametrised successor to the ALU overflow detector.
- Detects signed add/sub overflow on the execute-stage ALU result. Captures the faulting PC and exception cause, then raises a held trap request to the controller.
- Tracks the exception-level (EXL) state until ERET.
- Sits between the ALU outputs and the main controller/CP0 path.

---
 rtl/ovf_trap_unit.sv | 112 +++++++++++
 tb/tb_ovf_trap_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ovf_trap_unit.sv
// Signed add/sub overflow detector with held trap request, EPC/cause capture and EXL tracking.
// Optional overflow event counter is enabled by defining OVF_TRAP_COUNT_EN.
//
// state   | meaning
// IDLE    | no trap outstanding; an enabled overflow captures pc/cause
// PENDING | trap_req held high, waiting for trap_ack
// SERVICE | handler running (exl=1), waiting for eret
module ovf_trap_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [4:0]  ADD_OP     = 5'b00010,
  parameter logic [4:0]  SUB_OP     = 5'b00110,
  parameter logic [4:0]  OV_EXCCODE = 5'd12,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic [4:0]       alucont,
  input  logic [WIDTH-1:0] pc,
  input  logic             trap_en,
  input  logic             trap_ack,
  input  logic             eret,
`ifdef OVF_TRAP_COUNT_EN
  input  logic             cnt_clr,
  output logic [CNT_WIDTH-1:0] ovf_count,
`endif
  output logic             ovf,
  output logic             trap_req,
  output logic [WIDTH-1:0] epc,
  output logic [4:0]       cause,
  output logic             exl,
  output logic             lost
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE} state_t;
  state_t state;

  logic sa, sb, sr, raw;

  assign sa = a[WIDTH-1];
  assign sb = b[WIDTH-1];
  assign sr = result[WIDTH-1];

  always_comb begin
    raw = 1'b0;
    if (alucont == ADD_OP)      raw = (sa == sb) && (sr != sa);
    else if (alucont == SUB_OP) raw = (sa != sb) && (sr != sa);
  end

  assign ovf = valid && raw;

  // Only the sign bits matter for detection; the magnitude bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{a[WIDTH-2:0], b[WIDTH-2:0], result[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      trap_req <= 1'b0;
      epc      <= '0;
      cause    <= '0;
      exl      <= 1'b0;
      lost     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ovf && trap_en) begin
            epc      <= pc;
            cause    <= OV_EXCCODE;
            trap_req <= 1'b1;
            state    <= PENDING;
          end
        end
        PENDING: begin
          if (ovf) lost <= 1'b1;
          if (trap_ack) begin
            trap_req <= 1'b0;
            exl      <= 1'b1;
            state    <= SERVICE;
          end
        end
        SERVICE: begin
          // An overflow coinciding with eret is only recorded as lost, never trapped.
          if (ovf) lost <= 1'b1;
          if (eret) begin
            exl   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVF_TRAP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      ovf_count <= '0;
    else if (cnt_clr)
      ovf_count <= '0;
    else if (ovf && (ovf_count != {CNT_WIDTH{1'b1}}))
      ovf_count <= ovf_count + 1'b1;
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_ovf_trap_unit.sv
// Randomized + directed bench for ovf_trap_unit against a behavioural trap model.
// Define OVF_TRAP_COUNT_EN to also exercise the saturating counter (CNT_WIDTH=2).
module tb_ovf_trap_unit;
  localparam int W = 32;
  localparam logic [4:0] ADD = 5'b00010;
  localparam logic [4:0] SUB = 5'b00110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, valid, trap_en, trap_ack, eret, cnt_clr;
  logic [W-1:0] a, b, result, pc;
  logic [4:0]   alucont;
  logic         ovf, trap_req, exl, lost;
  logic [W-1:0] epc;
  logic [4:0]   cause;
  logic [1:0]   ovf_count;

  ovf_trap_unit #(.WIDTH(W), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .valid(valid), .a(a), .b(b), .result(result),
    .alucont(alucont), .pc(pc), .trap_en(trap_en), .trap_ack(trap_ack), .eret(eret),
`ifdef OVF_TRAP_COUNT_EN
    .cnt_clr(cnt_clr), .ovf_count(ovf_count),
`endif
    .ovf(ovf), .trap_req(trap_req), .epc(epc), .cause(cause), .exl(exl), .lost(lost)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a trap is either outstanding, being handled, or neither.
  bit           m_outstanding, m_in_handler, m_lost;
  logic [W-1:0] m_epc;
  logic [4:0]   m_cause;
  int           m_count;
  logic         ovf_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // True overflow: the exact signed result does not fit in W bits.
  function automatic bit model_ovf(input bit v, input logic [4:0] op,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
    longint s;
    if (!v) return 1'b0;
    if (op == ADD)      s = longint'($signed(x)) + longint'($signed(y));
    else if (op == SUB) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [W-1:0] true_res(input logic [4:0] op,
                                            input logic [W-1:0] x, input logic [W-1:0] y);
    return (op == SUB) ? x - y : x + y;
  endfunction

  // One clock: drive at negedge, check ovf, advance model at posedge, check registered outputs.
  task automatic cycle(input bit v, input logic [4:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] p, input bit en,
                       input bit ack, input bit er, input bit rst, input bit clr);
    bit mo;
    valid = v; alucont = op; a = x; b = y; result = true_res(op, x, y); pc = p;
    trap_en = en; trap_ack = ack; eret = er; reset = rst; cnt_clr = clr;
    #1;
    mo = model_ovf(v, op, x, y);
    ovf_seen = ovf;
    chk("ovf", ovf, mo);
    @(posedge clk);
    if (rst) begin
      m_outstanding = 0; m_in_handler = 0; m_lost = 0; m_epc = '0; m_cause = '0; m_count = 0;
    end else begin
      if (clr) m_count = 0;
      else if (mo && m_count < 3) m_count++;
      if (m_outstanding) begin
        if (mo) m_lost = 1;
        if (ack) begin m_outstanding = 0; m_in_handler = 1; end
      end else if (m_in_handler) begin
        if (mo) m_lost = 1;
        if (er) m_in_handler = 0;
      end else if (mo && en) begin
        m_outstanding = 1; m_epc = p; m_cause = 5'd12;
      end
    end
    #1;
    chk("trap_req", trap_req, m_outstanding);
    chk("exl", exl, m_in_handler);
    chk("lost", lost, m_lost);
    chk("epc", epc, m_epc);
    chk("cause", cause, m_cause);
`ifdef OVF_TRAP_COUNT_EN
    chk("ovf_count", ovf_count, m_count);
`endif
    @(negedge clk);
  endtask

  task automatic idle(input bit ack, input bit er);
    cycle(0, 5'd0, '0, '0, '0, 1, ack, er, 0, 0);
  endtask

  initial begin
    m_outstanding = 0; m_in_handler = 0; m_lost = 0; m_epc = '0; m_cause = '0; m_count = 0;
    @(negedge clk);
    cycle(0, 5'd0, '0, '0, '0, 0, 0, 0, 1, 0);
    cycle(0, 5'd0, '0, '0, '0, 0, 0, 0, 1, 0);
    chk("reset_trap_req", trap_req, 0);
    chk("reset_epc", epc, 0);

    // Directed add overflow, trap captured one cycle later.
    cycle(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h00400010, 1, 0, 0, 0, 0);
    chk("add_ovf_lit", ovf_seen, 1);
    chk("trap_req_lit", trap_req, 1);
    chk("epc_lit", epc, 32'h00400010);
    chk("cause_lit", cause, 12);
    for (int i = 0; i < 4; i++) idle(0, 0);
    chk("trap_held_lit", trap_req, 1);

    // Overflow while pending is dropped.
    cycle(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h00400020, 1, 0, 0, 0, 0);
    chk("lost_lit", lost, 1);
    chk("epc_frozen_lit", epc, 32'h00400010);
    cycle(1, SUB, 32'h80000000, 32'h1, 32'h0, 1, 0, 0, 0, 0);
    chk("sub_ovf_lit", ovf_seen, 1);
    cycle(1, SUB, 32'd5, 32'd3, 32'h0, 1, 0, 0, 0, 0);
    chk("sub_noovf_lit", ovf_seen, 0);
    cycle(1, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 1, 0, 0, 0, 0);
    chk("other_op_lit", ovf_seen, 0);

    idle(1, 0);
    chk("ack_exl_lit", exl, 1);
    chk("ack_req_lit", trap_req, 0);
    idle(1, 1);
    chk("eret_exl_lit", exl, 0);

    // Masked overflow captures nothing.
    cycle(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h00400030, 0, 0, 0, 0, 0);
    chk("masked_req_lit", trap_req, 0);
    chk("masked_epc_lit", epc, 32'h00400010);

    // Reset in PENDING, then a new trap right after.
    cycle(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h00400040, 1, 0, 0, 0, 0);
    cycle(0, 5'd0, '0, '0, '0, 1, 0, 0, 1, 0);
    chk("rst_mid_req_lit", trap_req, 0);
    chk("rst_mid_epc_lit", epc, 0);
    chk("rst_mid_lost_lit", lost, 0);
    cycle(1, ADD, 32'h80000000, 32'h80000000, 32'h00400050, 1, 0, 0, 0, 0);
    chk("post_rst_trap_lit", trap_req, 1);

`ifdef OVF_TRAP_COUNT_EN
    cycle(0, 5'd0, '0, '0, '0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, ADD, 32'h7FFFFFFF, 32'h1, '0, 0, 0, 0, 0, 0);
    chk("cnt_sat_lit", ovf_count, 3);
    cycle(1, ADD, 32'h7FFFFFFF, 32'h1, '0, 0, 0, 0, 0, 1);
    chk("cnt_clr_lit", ovf_count, 0);
`endif

    // Randomized traffic with operands biased toward the sign boundary.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]   op;
      logic [W-1:0] x, y;
      int sel;
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? ADD : (sel < 8) ? SUB : 5'($urandom);
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 1) == 1) x = {x[W-1], {3{~x[W-1]}}, x[W-5:0]};
      cycle($urandom_range(0, 3) != 0, op, x, y, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
